led_multi_strand_driver: RTL and testbench
==========================================

// Module: led_multi_strand_driver
// PURPOSE
//   Successor to the single-strand WS2812B driver. Drives NUM_STRANDS strands in lockstep from one bit timer.
//   Fetches per-LED GRB colour from a pattern module over a request/valid handshake, double-buffered so
//   fetching LED i+1 overlaps transmission of LED i. Sits between pat_* modules and the strand_out PMOD pins.
// PARAMETERS
//   NUM_STRANDS   4     strands driven in parallel (>=1)
//   NUM_LEDS      2     LEDs per strand (>=1)
//   COLOR_WIDTH   8     bits per colour channel; word = 3*COLOR_WIDTH, order G,R,B, MSB first
//   T0H_CYCLES    35    high time of a '0' bit (0.35 us @ 100 MHz)
//   T1H_CYCLES    70    high time of a '1' bit
//   BIT_CYCLES    125   full bit period; requires T0H < T1H < BIT
//   RESET_CYCLES  8000  latch/reset low time between frames (80 us)
//   LedW = max(1,$clog2(NUM_LEDS)), StrW = max(1,$clog2(NUM_STRANDS)) (localparams)
// PORTS
//   clk_in              in   1            100 MHz system clock
//   rst_in              in   1            asynchronous, active-high reset
//   force_reset         in   1            abort frame, restart with reset gap
//   strand_enable       in   NUM_STRANDS  per-strand output enable, sampled at frame start
//   next_led_request    out  LedW         LED index being requested
//   next_strand_request out  StrW         strand index being requested
//   request_valid       out  1            request outstanding; index held stable while high
//   green_in/red_in/blue_in in COLOR_WIDTH colour for the outstanding request
//   color_valid         in   1            colour accepted when request_valid=1 this cycle
//   strand_out          out  NUM_STRANDS  WS2812B data lines
//   frame_done          out  1            1-cycle pulse after last bit of LED NUM_LEDS-1
//   underrun            out  1            sticky: fetch missed an LED boundary; cleared only by rst_in
// BEHAVIOUR
//   Reset: strand_out=0, request_valid=0, indices=0, frame_done=0, underrun=0, state=LATCH, counters=0.
//   States: LATCH -> PRIME -> SEND -> (LATCH after last LED | SEND next LED | LATCH on underrun).
//   LATCH: all lines low for RESET_CYCLES; latches strand_enable; then PRIME.
//   PRIME: fetch LED 0 for strands 0..NUM_STRANDS-1 into staging; lines low; when all stored, copy staging
//     into per-strand shift regs same cycle -> SEND.
//   Fetch engine: raises request_valid with (led,strand); on color_valid&&request_valid stores {G,R,B} in
//     staging[strand], drops request_valid next cycle if last strand else advances strand index (back-to-back
//     accept allowed, min 1 cycle/strand). color_valid when request_valid=0 is ignored.
//   SEND: bit timer 0..BIT_CYCLES-1; line k high while timer < (shift_k MSB ? T1H : T0H) and enable_k, else low.
//     Shift at timer wrap. During LED i, engine fetches LED i+1 (none for last LED).
//   LED boundary (24th bit wrap, bit counter 3*COLOR_WIDTH-1): staging full -> load, continue next cycle with
//     no gap; staging not full -> underrun=1, drop request_valid, go LATCH, restart at LED 0.
//   Last LED boundary: frame_done pulses, -> LATCH. Frames repeat continuously.
//   force_reset: next cycle strand_out=0, request_valid=0, staging cleared, -> LATCH (full RESET_CYCLES).
//     Has priority over boundary and fetch events in the same cycle.
//   Disabled strands: still fetched (handshake identical), output forced 0.
//   rst_in asserted mid-frame: all outputs to reset values immediately (async).
// STRUCTURE
//   led_pkg: state enum (LATCH,PRIME,SEND), grb_t struct {g,r,b}, WS2812B timing defaults.
//   Sub-module led_fetch_ctrl: request/valid sequencing + staging buffer, start/full/clear interface.
//   Top: FSM, bit timer, bit/LED counters, NUM_STRANDS shift regs, output compare.
// TESTING (NUM_STRANDS=2, NUM_LEDS=2, T0H=2, T1H=4, BIT=6, RESET=20)
//   Release reset -> strand_out=00 for 20 cycles, then request_valid=1 with led=0, strand=0.
//   Answer 1-cycle latency: s0 GRB=0x80_00_01, s1 0x00_00_00 -> first bit s0 high 4, s1 high 2; s0 last bit high 4.
//   Withhold color_valid for LED 1 beyond 144 cycles -> underrun=1 at boundary, lines low 20 cycles, request led 0.
//   force_reset mid-bit of LED 0 -> strand_out=00 next cycle, request_valid=0, 20-cycle gap, PRIME restarts.
//   strand_enable=01 -> strand_out[1]=0 entire frame; requests still cover both strands per LED.
//   Stray color_valid with request_valid=0 -> no staging change; frame_done pulses exactly once per frame.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and WS2812B timing defaults for the multi-strand LED driver.
package led_pkg;

    typedef enum logic [1:0] {
        ST_LATCH = 2'd0,
        ST_PRIME = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    localparam int unsigned DEF_COLOR_WIDTH  = 8;
    localparam int unsigned DEF_T0H_CYCLES   = 35;
    localparam int unsigned DEF_T1H_CYCLES   = 70;
    localparam int unsigned DEF_BIT_CYCLES   = 125;
    localparam int unsigned DEF_RESET_CYCLES = 8000;

    typedef struct packed {
        logic [DEF_COLOR_WIDTH-1:0] g;
        logic [DEF_COLOR_WIDTH-1:0] r;
        logic [DEF_COLOR_WIDTH-1:0] b;
    } grb_t;

    // Index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_fetch_ctrl.sv
// Request/valid fetch engine: walks strands 0..NUM_STRANDS-1 for one LED and fills the staging buffer.
module led_fetch_ctrl
    import led_pkg::*;
#(
    parameter int unsigned NUM_STRANDS = 4,
    parameter int unsigned NUM_LEDS    = 2,
    parameter int unsigned COLOR_WIDTH = DEF_COLOR_WIDTH,
    localparam int unsigned LedW  = clog2_min1(NUM_LEDS),
    localparam int unsigned StrW  = clog2_min1(NUM_STRANDS),
    localparam int unsigned WordW = 3 * COLOR_WIDTH
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           start_c,
    input  logic [LedW-1:0]                start_led_c,
    input  logic                           consume_c,
    input  logic                           clear_c,
    input  logic [COLOR_WIDTH-1:0]         green_in,
    input  logic [COLOR_WIDTH-1:0]         red_in,
    input  logic [COLOR_WIDTH-1:0]         blue_in,
    input  logic                           color_valid,
    output logic                           request_valid,
    output logic [LedW-1:0]                next_led_request,
    output logic [StrW-1:0]                next_strand_request,
    output logic [NUM_STRANDS*WordW-1:0]   staging,
    output logic                           staging_full
);

    logic last_strand_c;
    logic accept_c;

    assign last_strand_c = (next_strand_request == StrW'(NUM_STRANDS - 1));
    assign accept_c      = request_valid && color_valid;

    // Clear beats start/consume, which beat a colour acceptance in the same cycle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            request_valid       <= 1'b0;
            next_led_request    <= '0;
            next_strand_request <= '0;
            staging             <= '0;
            staging_full        <= 1'b0;
        end else if (clear_c) begin
            request_valid       <= 1'b0;
            next_led_request    <= '0;
            next_strand_request <= '0;
            staging             <= '0;
            staging_full        <= 1'b0;
        end else if (start_c) begin
            request_valid       <= 1'b1;
            next_led_request    <= start_led_c;
            next_strand_request <= '0;
            staging_full        <= 1'b0;
        end else begin
            if (consume_c) begin
                staging_full <= 1'b0;
            end
            if (accept_c) begin
                staging[int'(next_strand_request)*WordW +: WordW] <= {green_in, red_in, blue_in};
                if (last_strand_c) begin
                    request_valid <= 1'b0;
                    staging_full  <= 1'b1;
                end else begin
                    next_strand_request <= next_strand_request + StrW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/led_multi_strand_driver.sv
// WS2812B driver for NUM_STRANDS parallel strands sharing one bit timer, with a
// double-buffered colour fetch so the next LED is gathered while the current one shifts out.
module led_multi_strand_driver
    import led_pkg::*;
#(
    parameter int unsigned NUM_STRANDS  = 4,
    parameter int unsigned NUM_LEDS     = 2,
    parameter int unsigned COLOR_WIDTH  = DEF_COLOR_WIDTH,
    parameter int unsigned T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int unsigned T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int unsigned BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
    localparam int unsigned LedW = clog2_min1(NUM_LEDS),
    localparam int unsigned StrW = clog2_min1(NUM_STRANDS)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   force_reset,
    input  logic [NUM_STRANDS-1:0] strand_enable,
    output logic [LedW-1:0]        next_led_request,
    output logic [StrW-1:0]        next_strand_request,
    output logic                   request_valid,
    input  logic [COLOR_WIDTH-1:0] green_in,
    input  logic [COLOR_WIDTH-1:0] red_in,
    input  logic [COLOR_WIDTH-1:0] blue_in,
    input  logic                   color_valid,
    output logic [NUM_STRANDS-1:0] strand_out,
    output logic                   frame_done,
    output logic                   underrun
);

    localparam int unsigned WordW  = 3 * COLOR_WIDTH;
    localparam int unsigned TmrMax = (RESET_CYCLES > BIT_CYCLES) ? RESET_CYCLES : BIT_CYCLES;
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);
    localparam int unsigned BitW   = clog2_min1(WordW);

    state_t                   state_q, state_d;
    logic [TmrW-1:0]          tmr_q, tmr_d;
    logic [BitW-1:0]          bit_q, bit_d;
    logic [LedW-1:0]          led_q, led_d;
    logic [NUM_STRANDS-1:0]   en_q, en_d;
    logic [WordW-1:0]         shift_q [NUM_STRANDS];
    logic [WordW-1:0]         shift_d [NUM_STRANDS];
    logic [NUM_STRANDS-1:0]   out_d;
    logic                     frame_done_d;
    logic                     underrun_d;

    logic                     start_c;
    logic [LedW-1:0]          start_led_c;
    logic                     consume_c;
    logic                     clear_c;
    logic                     load_c;
    logic [NUM_STRANDS*WordW-1:0] staging;
    logic                     staging_full;

    led_fetch_ctrl #(
        .NUM_STRANDS (NUM_STRANDS),
        .NUM_LEDS    (NUM_LEDS),
        .COLOR_WIDTH (COLOR_WIDTH)
    ) u_fetch (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .start_c             (start_c),
        .start_led_c         (start_led_c),
        .consume_c           (consume_c),
        .clear_c             (clear_c),
        .green_in            (green_in),
        .red_in              (red_in),
        .blue_in             (blue_in),
        .color_valid         (color_valid),
        .request_valid       (request_valid),
        .next_led_request    (next_led_request),
        .next_strand_request (next_strand_request),
        .staging             (staging),
        .staging_full        (staging_full)
    );

    // Next-state, counters, shift registers and line levels.
    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        bit_d        = bit_q;
        led_d        = led_q;
        en_d         = en_q;
        shift_d      = shift_q;
        out_d        = '0;
        frame_done_d = 1'b0;
        underrun_d   = underrun;
        start_c      = 1'b0;
        start_led_c  = '0;
        consume_c    = 1'b0;
        clear_c      = 1'b0;
        load_c       = 1'b0;

        if (force_reset) begin
            state_d = ST_LATCH;
            tmr_d   = '0;
            bit_d   = '0;
            led_d   = '0;
            clear_c = 1'b1;
        end else begin
            case (state_q)
                ST_LATCH: begin
                    if (tmr_q == TmrW'(RESET_CYCLES - 1)) begin
                        state_d = ST_PRIME;
                        tmr_d   = '0;
                        en_d    = strand_enable;
                        start_c = 1'b1;
                    end else begin
                        tmr_d = tmr_q + TmrW'(1);
                    end
                end
                ST_PRIME: begin
                    if (staging_full) begin
                        state_d   = ST_SEND;
                        tmr_d     = '0;
                        bit_d     = '0;
                        led_d     = '0;
                        consume_c = 1'b1;
                        load_c    = 1'b1;
                        if (NUM_LEDS > 1) begin
                            start_c     = 1'b1;
                            start_led_c = LedW'(1);
                        end
                    end
                end
                ST_SEND: begin
                    for (int unsigned k = 0; k < NUM_STRANDS; k++) begin
                        out_d[k] = en_q[k] &&
                                   (32'(tmr_q) < (shift_q[k][WordW-1] ? T1H_CYCLES : T0H_CYCLES));
                    end
                    if (tmr_q == TmrW'(BIT_CYCLES - 1)) begin
                        tmr_d = '0;
                        for (int unsigned k = 0; k < NUM_STRANDS; k++) begin
                            shift_d[k] = {shift_q[k][WordW-2:0], 1'b0};
                        end
                        if (bit_q == BitW'(WordW - 1)) begin
                            bit_d = '0;
                            if (led_q == LedW'(NUM_LEDS - 1)) begin
                                state_d      = ST_LATCH;
                                led_d        = '0;
                                frame_done_d = 1'b1;
                            end else if (staging_full) begin
                                led_d     = led_q + LedW'(1);
                                consume_c = 1'b1;
                                load_c    = 1'b1;
                                if (32'(led_q) + 32'd2 < NUM_LEDS) begin
                                    start_c     = 1'b1;
                                    start_led_c = LedW'(32'(led_q) + 32'd2);
                                end
                            end else begin
                                // Next LED not fetched in time: abandon the frame.
                                state_d    = ST_LATCH;
                                led_d      = '0;
                                underrun_d = 1'b1;
                                clear_c    = 1'b1;
                            end
                        end else begin
                            bit_d = bit_q + BitW'(1);
                        end
                    end else begin
                        tmr_d = tmr_q + TmrW'(1);
                    end
                end
                default: begin
                    state_d = ST_LATCH;
                    tmr_d   = '0;
                end
            endcase
        end

        if (load_c) begin
            for (int unsigned k = 0; k < NUM_STRANDS; k++) begin
                shift_d[k] = staging[k*WordW +: WordW];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_LATCH;
            tmr_q      <= '0;
            bit_q      <= '0;
            led_q      <= '0;
            en_q       <= '0;
            strand_out <= '0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            for (int unsigned k = 0; k < NUM_STRANDS; k++) begin
                shift_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            bit_q      <= bit_d;
            led_q      <= led_d;
            en_q       <= en_d;
            strand_out <= out_d;
            frame_done <= frame_done_d;
            underrun   <= underrun_d;
            for (int unsigned k = 0; k < NUM_STRANDS; k++) begin
                shift_q[k] <= shift_d[k];
            end
        end
    end

endmodule

// File: tb/tb_led_multi_strand_driver.sv
// Bench for led_multi_strand_driver: a colour responder plus a pulse-decoding model of the strand lines.
module tb_led_multi_strand_driver;

    localparam int unsigned NS   = 2;
    localparam int unsigned NL   = 2;
    localparam int unsigned CW   = 8;
    localparam int unsigned T0H  = 2;
    localparam int unsigned T1H  = 4;
    localparam int unsigned BITC = 6;
    localparam int unsigned RSTC = 20;
    localparam int unsigned WW   = 3 * CW;

    logic           clk_in = 1'b0;
    logic           rst_in = 1'b1;
    logic           force_reset = 1'b0;
    logic [NS-1:0]  strand_enable = '1;
    logic [0:0]     next_led_request;
    logic [0:0]     next_strand_request;
    logic           request_valid;
    logic [CW-1:0]  green_in = '0;
    logic [CW-1:0]  red_in = '0;
    logic [CW-1:0]  blue_in = '0;
    logic           color_valid = 1'b0;
    logic [NS-1:0]  strand_out;
    logic           frame_done;
    logic           underrun;

    led_multi_strand_driver #(
        .NUM_STRANDS  (NS),
        .NUM_LEDS     (NL),
        .COLOR_WIDTH  (CW),
        .T0H_CYCLES   (T0H),
        .T1H_CYCLES   (T1H),
        .BIT_CYCLES   (BITC),
        .RESET_CYCLES (RSTC)
    ) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .force_reset         (force_reset),
        .strand_enable       (strand_enable),
        .next_led_request    (next_led_request),
        .next_strand_request (next_strand_request),
        .request_valid       (request_valid),
        .green_in            (green_in),
        .red_in              (red_in),
        .blue_in             (blue_in),
        .color_valid         (color_valid),
        .strand_out          (strand_out),
        .frame_done          (frame_done),
        .underrun            (underrun)
    );

    always #5 clk_in = ~clk_in;

    int            ncmp = 0;
    int            nfail = 0;
    logic [WW-1:0] tbl [NL][NS];
    logic [NS-1:0] tr_out [$];
    logic          tr_fd [$];
    int            lat = 1;
    int            wcnt = 0;
    bit            answer_led1 = 1'b1;
    bit            stray = 1'b0;
    int            exp_led = 0;
    int            exp_str = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: score any handshake completing at this edge, log outputs, then drive the responder.
    task automatic tick();
        if (color_valid && request_valid && !force_reset && !rst_in) begin
            check("fetch_led", 64'(next_led_request), 64'(exp_led));
            check("fetch_strand", 64'(next_strand_request), 64'(exp_str));
            exp_str++;
            if (exp_str == int'(NS)) begin
                exp_str = 0;
                exp_led = (exp_led + 1) % int'(NL);
            end
        end
        @(posedge clk_in);
        #1;
        tr_out.push_back(strand_out);
        tr_fd.push_back(frame_done);
        color_valid = 1'b0;
        if (request_valid && (answer_led1 || next_led_request == 1'b0)) begin
            if (wcnt >= lat) begin
                color_valid = 1'b1;
                {green_in, red_in, blue_in} = tbl[next_led_request][next_strand_request];
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else if (!request_valid) begin
            wcnt = 0;
            if (stray) begin
                color_valid = 1'b1;
                {green_in, red_in, blue_in} = 24'($urandom);
            end
        end
    endtask

    // Decode one line: pulse widths give the bits, rising edges must be one bit period apart.
    task automatic decode(input int from, input int to, input int line,
                          output logic [63:0] bits, output int npulse, output int nbad);
        int   rise_prev;
        int   hi;
        logic prev;
        bits = '0; npulse = 0; nbad = 0; rise_prev = -1; hi = 0; prev = 1'b0;
        for (int i = from; i < to; i++) begin
            logic [NS-1:0] v;
            logic          cur;
            v   = tr_out[i];
            cur = v[line];
            if (cur && !prev) begin
                if (rise_prev >= 0 && (i - rise_prev) != int'(BITC)) nbad++;
                rise_prev = i;
                hi = 0;
            end
            if (cur) hi++;
            if (!cur && prev) begin
                npulse++;
                if (hi == int'(T1H)) bits = {bits[62:0], 1'b1};
                else if (hi == int'(T0H)) bits = {bits[62:0], 1'b0};
                else nbad++;
            end
            prev = cur;
        end
        if (prev) nbad++;
    endtask

    function automatic int nth_width(input int from, input int to, input int line, input int nth);
        int            cnt;
        int            w;
        logic          prev;
        logic [NS-1:0] v;
        cnt = 0; w = 0; prev = 1'b0;
        for (int i = from; i < to; i++) begin
            v = tr_out[i];
            if (v[line]) begin
                w++;
            end else if (prev) begin
                cnt++;
                if (cnt == nth) return w;
                w = 0;
            end
            prev = v[line];
        end
        return -1;
    endfunction

    task automatic verify_lines(input string tag, input int from, input int to,
                                input logic [NS-1:0] en, input int nleds);
        logic [63:0] bits;
        logic [63:0] expw;
        int          npulse;
        int          nbad;
        for (int k = 0; k < int'(NS); k++) begin
            decode(from, to, k, bits, npulse, nbad);
            check({tag, "_bad_pulse"}, 64'(nbad), 64'(0));
            if (en[k]) begin
                expw = '0;
                for (int l = 0; l < nleds; l++) expw = (expw << WW) | 64'(tbl[l][k]);
                check({tag, "_npulse"}, 64'(npulse), 64'(nleds * int'(WW)));
                check({tag, "_grb"}, bits, expw);
            end else begin
                check({tag, "_disabled_quiet"}, 64'(npulse), 64'(0));
            end
        end
    endtask

    // Lines low and no request for RESET_CYCLES, then a request for LED 0 strand 0.
    task automatic check_gap(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < int'(RSTC) - 1; i++) begin
            tick();
            if (request_valid !== 1'b0 || strand_out !== '0) bad++;
        end
        check({tag, "_gap_low"}, 64'(bad), 64'(0));
        tick();
        check({tag, "_req_rise"}, 64'(request_valid), 64'(1));
        check({tag, "_req_led"}, 64'(next_led_request), 64'(0));
        check({tag, "_req_strand"}, 64'(next_strand_request), 64'(0));
    endtask

    task automatic run_frame(input string tag, input logic [NS-1:0] en, input int budget, output int base);
        int n;
        int fd_cnt;
        bit done;
        base = tr_out.size(); n = 0; done = 1'b0;
        while (!done && n < budget) begin
            tick();
            n++;
            if (frame_done) done = 1'b1;
        end
        check({tag, "_frame_done"}, 64'(done), 64'(1));
        fd_cnt = 0;
        for (int i = base; i < tr_fd.size(); i++) if (tr_fd[i]) fd_cnt++;
        check({tag, "_fd_once"}, 64'(fd_cnt), 64'(1));
        verify_lines(tag, base, tr_out.size(), en, int'(NL));
    endtask

    task automatic randomize_tbl();
        for (int l = 0; l < int'(NL); l++)
            for (int k = 0; k < int'(NS); k++)
                tbl[l][k] = 24'($urandom);
    endtask

    initial begin
        int base;
        int n;

        // Reset values while rst_in is held.
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_strand_out", 64'(strand_out), 64'(0));
        check("rst_req_valid", 64'(request_valid), 64'(0));
        check("rst_frame_done", 64'(frame_done), 64'(0));
        check("rst_underrun", 64'(underrun), 64'(0));
        check("rst_led_idx", 64'(next_led_request), 64'(0));
        check("rst_strand_idx", 64'(next_strand_request), 64'(0));

        // Directed first frame, one-cycle answer latency.
        randomize_tbl();
        tbl[0][0] = 24'h80_00_01;
        tbl[0][1] = 24'h00_00_00;
        lat = 1;
        rst_in = 1'b0;
        check_gap("boot");
        run_frame("f1", 2'b11, 600, base);
        check("f1_s0_first_w", 64'(nth_width(base, tr_out.size(), 0, 1)), 64'(T1H));
        check("f1_s1_first_w", 64'(nth_width(base, tr_out.size(), 1, 1)), 64'(T0H));
        check("f1_s0_bit24_w", 64'(nth_width(base, tr_out.size(), 0, 24)), 64'(T1H));
        check("f1_underrun", 64'(underrun), 64'(0));

        // Strand 1 disabled; enable flips back mid-frame but must not take effect until next frame.
        randomize_tbl();
        lat = 0;
        strand_enable = 2'b01;
        check_gap("f2");
        strand_enable = 2'b11;
        run_frame("f2", 2'b01, 600, base);

        // Randomized frames: latency, enables and stray color_valid vary.
        for (int r = 0; r < 4; r++) begin
            logic [NS-1:0] en;
            randomize_tbl();
            lat = int'($urandom_range(0, 3));
            en = NS'($urandom_range(0, 3));
            stray = (r % 2) == 1;
            strand_enable = en;
            check_gap("rnd");
            run_frame("rnd", en, 600, base);
        end
        stray = 1'b0;
        strand_enable = 2'b11;

        // Underrun: LED 1 colour withheld past the LED 0 boundary.
        randomize_tbl();
        lat = 1;
        answer_led1 = 1'b0;
        check_gap("ur");
        base = tr_out.size();
        n = 0;
        while (!underrun && n < 600) begin
            tick();
            n++;
        end
        check("ur_seen", 64'(underrun), 64'(1));
        check("ur_req_drop", 64'(request_valid), 64'(0));
        check("ur_no_frame_done", 64'(tr_fd.sum() with (int'(item))), 64'(4 + 2));
        verify_lines("ur_led0", base, tr_out.size(), 2'b11, 1);
        exp_led = 0;
        exp_str = 0;
        answer_led1 = 1'b1;
        check_gap("ur_restart");
        run_frame("post_ur", 2'b11, 600, base);
        check("ur_sticky", 64'(underrun), 64'(1));

        // force_reset in the middle of the first bit of LED 0 while LED 1 is still being fetched.
        randomize_tbl();
        lat = 10;
        check_gap("fr");
        n = 0;
        while (strand_out === '0 && n < 100) begin
            tick();
            n++;
        end
        check("fr_send_seen", 64'(strand_out !== '0), 64'(1));
        tick();
        tick();
        check("fr_fetch_pending", 64'(request_valid), 64'(1));
        force_reset = 1'b1;
        tick();
        force_reset = 1'b0;
        check("fr_lines_low", 64'(strand_out), 64'(0));
        check("fr_req_drop", 64'(request_valid), 64'(0));
        exp_led = 0;
        exp_str = 0;
        check_gap("fr_restart");
        run_frame("post_fr", 2'b11, 800, base);

        // Asynchronous reset mid-frame clears outputs without waiting for a clock edge.
        randomize_tbl();
        lat = 1;
        check_gap("ar");
        n = 0;
        while (strand_out === '0 && n < 100) begin
            tick();
            n++;
        end
        #2;
        rst_in = 1'b1;
        #1;
        check("ar_strand_out", 64'(strand_out), 64'(0));
        check("ar_req_valid", 64'(request_valid), 64'(0));
        check("ar_underrun", 64'(underrun), 64'(0));
        check("ar_frame_done", 64'(frame_done), 64'(0));
        color_valid = 1'b0;
        wcnt = 0;
        exp_led = 0;
        exp_str = 0;
        rst_in = 1'b0;
        check_gap("ar_boot");
        run_frame("post_ar", 2'b11, 600, base);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
